// File: rtl/fetch_stage_pkg.sv
// Shared fetch constants, FSM state type and an address helper.
// The control unit imports this package too, so the bubble and end-opcode
// encodings are defined once here.
package fetch_stage_pkg;

    // NOP injected on flush: opcode 000000, funct 111111
    localparam logic [31:0] BUBBLE_INSTR = 32'h0000003F;
    // Opcode that marks the end of the program
    localparam logic [5:0]  OP_END       = 6'b111111;
    // Number of bubble cycles issued after the end word before halting
    localparam int          DRAIN_CYCLES = 4;
    // Drain counter value on which the next unstalled edge enters HALT
    localparam logic [2:0]  DRAIN_LAST   = 3'(DRAIN_CYCLES - 1);

    typedef enum logic [1:0] {
        RUN   = 2'd0,
        DRAIN = 2'd1,
        HALT  = 2'd2
    } fetch_state_t;

    // Redirect targets are byte addresses; fetch is always word aligned
    function automatic logic [31:0] word_align(input logic [31:0] addr);
        return {addr[31:2], 2'b00};
    endfunction

endpackage

// File: rtl/fetch_stage_if.sv
// Fetch-stage bundle: redirect/hazard inputs, instruction memory bus and
// IF/ID outputs. master = fetch stage, slave = surrounding pipeline/memory.
interface fetch_stage_if;
    logic        stall;
    logic        branch_taken;
    logic [31:0] branch_target;
    logic        jump;
    logic [31:0] jump_target;
    logic        jreg;
    logic [31:0] jr_target;
    logic [31:0] imem_data;
    logic [31:0] imem_addr;
    logic [31:0] PCF;
    logic [31:0] InstrD;
    logic [31:0] PCPlus4D;
    logic        halted;

    modport master (
        input  stall, branch_taken, branch_target, jump, jump_target,
               jreg, jr_target, imem_data,
        output imem_addr, PCF, InstrD, PCPlus4D, halted
    );

    modport slave (
        output stall, branch_taken, branch_target, jump, jump_target,
               jreg, jr_target, imem_data,
        input  imem_addr, PCF, InstrD, PCPlus4D, halted
    );
endinterface

// File: rtl/fetch_stage_ifid_reg.sv
// IF/ID pipeline register: holds the fetched instruction and its PC+4.
// en freezes the register; flush replaces the contents with a bubble.
module ifid_reg
    import fetch_stage_pkg::*;
(
    input  logic        clk,
    input  logic        rst,
    input  logic        en,
    input  logic        flush,
    input  logic [31:0] i_instr,
    input  logic [31:0] i_pcplus4,
    output logic [31:0] o_instr,
    output logic [31:0] o_pcplus4
);

    logic [31:0] r_instr;
    logic [31:0] r_pcplus4;

    // Capture, flush to bubble, or hold the decode-stage instruction
    always_ff @(posedge clk) begin
        if (rst) begin
            r_instr   <= BUBBLE_INSTR;
            r_pcplus4 <= 32'd0;
        end else if (en) begin
            if (flush) begin
                r_instr   <= BUBBLE_INSTR;
                r_pcplus4 <= 32'd0;
            end else begin
                r_instr   <= i_instr;
                r_pcplus4 <= i_pcplus4;
            end
        end
    end

    assign o_instr   = r_instr;
    assign o_pcplus4 = r_pcplus4;

endmodule

// File: rtl/fetch_stage.sv
// Instruction fetch stage: PC register, next-PC selection, end-of-program
// drain/halt FSM and the IF/ID register. Stall freezes everything; once the
// end word is seen the pipeline is fed bubbles and then parks in HALT.
module fetch_stage
    import fetch_stage_pkg::*;
(
    input logic          clk,
    input logic          rst,
    fetch_stage_if.master bus
);

    fetch_state_t r_state;
    fetch_state_t w_state_next;
    logic [31:0]  r_pc;
    logic [31:0]  w_pc_next;
    logic [2:0]   r_drain_cnt;
    logic [2:0]   w_drain_cnt_next;
    logic         r_halted;
    logic         w_flush;
    logic         w_redirect;
    logic [31:0]  w_target;
    logic         w_is_end;
    logic [31:0]  w_pc_plus4;
    logic [31:0]  w_instr_d;
    logic [31:0]  w_pcplus4_d;

    assign w_pc_plus4 = r_pc + 32'd4;
    assign w_is_end   = (bus.imem_data[31:26] == OP_END);

    // Redirect source selection: jr beats j/jal beats taken branch
    always_comb begin
        w_redirect = bus.jreg | bus.jump | bus.branch_taken;
        if (bus.jreg)
            w_target = word_align(bus.jr_target);
        else if (bus.jump)
            w_target = word_align(bus.jump_target);
        else
            w_target = word_align(bus.branch_target);
    end

    // FSM state register; a stall holds the state
    always_ff @(posedge clk) begin
        if (rst)
            r_state <= RUN;
        else if (!bus.stall)
            r_state <= w_state_next;
    end

    // FSM next-state: end word (not flushed by a redirect) starts the drain
    always_comb begin
        w_state_next = r_state;
        case (r_state)
            RUN:     if (!w_redirect && w_is_end) w_state_next = DRAIN;
            DRAIN:   if (r_drain_cnt == DRAIN_LAST) w_state_next = HALT;
            HALT:    w_state_next = HALT;
            default: w_state_next = RUN;
        endcase
    end

    // FSM outputs: next PC, drain counter update and IF/ID flush request
    always_comb begin
        w_pc_next        = r_pc;
        w_drain_cnt_next = r_drain_cnt;
        w_flush          = 1'b0;
        case (r_state)
            RUN: begin
                if (w_redirect) begin
                    w_pc_next = w_target;
                    w_flush   = 1'b1;
                end else if (w_is_end) begin
                    w_drain_cnt_next = 3'd0;
                end else begin
                    w_pc_next = w_pc_plus4;
                end
            end
            DRAIN: begin
                w_flush          = 1'b1;
                w_drain_cnt_next = r_drain_cnt + 3'd1;
            end
            default: begin
                // HALT keeps feeding bubbles, which leaves IF/ID unchanged
                w_flush = 1'b1;
            end
        endcase
    end

    // PC, drain counter and registered halted flag
    always_ff @(posedge clk) begin
        if (rst) begin
            r_pc        <= 32'd0;
            r_drain_cnt <= 3'd0;
            r_halted    <= 1'b0;
        end else if (!bus.stall) begin
            r_pc        <= w_pc_next;
            r_drain_cnt <= w_drain_cnt_next;
            r_halted    <= (w_state_next == HALT);
        end
    end

    ifid_reg u_ifid (
        .clk       (clk),
        .rst       (rst),
        .en        (~bus.stall),
        .flush     (w_flush),
        .i_instr   (bus.imem_data),
        .i_pcplus4 (w_pc_plus4),
        .o_instr   (w_instr_d),
        .o_pcplus4 (w_pcplus4_d)
    );

    assign bus.imem_addr = r_pc;
    assign bus.PCF       = r_pc;
    assign bus.InstrD    = w_instr_d;
    assign bus.PCPlus4D  = w_pcplus4_d;
    assign bus.halted    = r_halted;

endmodule
